// File: rtl/uncache_arbiter_pkg.sv
// Shared constants and state encoding for the uncached bus arbiter.
package uncache_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [7:0] UARB_IF_MASK = 8'hFF;

  typedef enum logic [1:0] {
    UARB_IDLE   = 2'd0,
    UARB_IF_BUS = 2'd1,
    UARB_DM_BUS = 2'd2,
    UARB_RESP   = 2'd3
  } uarb_state_e;

endpackage

// File: rtl/uncache_arbiter_pick.sv
// Combinational winner select between fetch and data requesters.
// UNCACHE_ARB_RR_EN selects round-robin on ptr (1 = data side preferred); otherwise data side wins.
module uarb_pick
  import uncache_arbiter_pkg::*;
(
  input  logic if_pend,
  input  logic dm_pend,
  input  logic ptr,
  output logic pick_if,
  output logic pick_dm
);

`ifdef UNCACHE_ARB_RR_EN
  assign pick_dm = dm_pend & (~if_pend | ptr);
  assign pick_if = if_pend & ~pick_dm;
`else
  logic ptr_unused;
  assign ptr_unused = ptr;
  assign pick_dm    = dm_pend;
  assign pick_if    = if_pend & ~dm_pend;
`endif

endmodule

// File: rtl/uncache_arbiter.sv
// Arbiter/sequencer for the single uncached bus port feeding the AXI bridge.
// UNCACHE_ARB_RR_EN enables round-robin arbitration (default: data side has fixed priority).
//   state  | meaning
//   IDLE   | no request outstanding
//   IF_BUS | fetch request on the bus
//   DM_BUS | data request on the bus
//   RESP   | completion being returned
module uncache_arbiter
  import uncache_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_re,
  output logic [DATA_W-1:0] if_data,
  output logic              if_finish,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  input  logic [7:0]        dm_mask,
  input  logic              dm_we,
  input  logic              dm_re,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_finish,
  output logic [ADDR_W-1:0] arb_addr,
  output logic [DATA_W-1:0] arb_data,
  output logic [7:0]        arb_mask,
  output logic              arb_we,
  output logic              arb_re,
  input  logic [DATA_W-1:0] in_arb_data,
  input  logic              in_arb_finish,
  output logic              busy
);

  uarb_state_e       state_q, state_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        mask_q, mask_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic if_pend, dm_pend, ptr, pick_if, pick_dm;

  assign if_pend = if_re;
  assign dm_pend = dm_we | dm_re;

`ifdef UNCACHE_ARB_RR_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;

  // Pointer names the side that did not just win.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == UARB_IDLE && (pick_if | pick_dm)) ptr_d = pick_if;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr = 1'b0;
`endif

  uarb_pick u_pick (
    .if_pend (if_pend),
    .dm_pend (dm_pend),
    .ptr     (ptr),
    .pick_if (pick_if),
    .pick_dm (pick_dm)
  );

  always_comb begin
    state_d  = state_q;
    gnt_dm_d = gnt_dm_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    we_d     = we_q;
    re_d     = re_q;
    rdata_d  = rdata_q;
    case (state_q)
      UARB_IDLE: begin
        if (pick_dm) begin
          state_d  = UARB_DM_BUS;
          gnt_dm_d = ENABLE;
          addr_d   = dm_addr;
          data_d   = dm_data;
          mask_d   = dm_mask;
          we_d     = dm_we;
          re_d     = dm_re & ~dm_we;
        end else if (pick_if) begin
          state_d  = UARB_IF_BUS;
          gnt_dm_d = DISABLE;
          addr_d   = if_addr;
          data_d   = '0;
          mask_d   = UARB_IF_MASK;
          we_d     = DISABLE;
          re_d     = ENABLE;
        end
      end
      UARB_IF_BUS, UARB_DM_BUS: begin
        if (in_arb_finish) begin
          rdata_d = in_arb_data;
          we_d    = DISABLE;
          re_d    = DISABLE;
          state_d = UARB_RESP;
        end
      end
      UARB_RESP: state_d = UARB_IDLE;
      default:   state_d = UARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UARB_IDLE;
      gnt_dm_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_dm_q <= gnt_dm_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      we_q     <= we_d;
      re_q     <= re_d;
      rdata_q  <= rdata_d;
    end
  end

  assign if_finish = (state_q == UARB_RESP) & ~gnt_dm_q;
  assign dm_finish = (state_q == UARB_RESP) &  gnt_dm_q;
  assign if_data   = if_finish ? rdata_q : '0;
  assign dm_rdata  = dm_finish ? rdata_q : '0;
  assign arb_addr  = addr_q;
  assign arb_data  = data_q;
  assign arb_mask  = mask_q;
  assign arb_we    = we_q;
  assign arb_re    = re_q;
  assign busy      = (state_q != UARB_IDLE);

endmodule

// File: tb/tb_uncache_arbiter.sv
// Directed bench for uncache_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_uncache_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_addr;
  logic        if_re;
  logic [63:0] if_data;
  logic        if_finish;
  logic [63:0] dm_addr;
  logic [63:0] dm_data;
  logic [7:0]  dm_mask;
  logic        dm_we;
  logic        dm_re;
  logic [63:0] dm_rdata;
  logic        dm_finish;
  logic [63:0] arb_addr;
  logic [63:0] arb_data;
  logic [7:0]  arb_mask;
  logic        arb_we;
  logic        arb_re;
  logic [63:0] in_arb_data;
  logic        in_arb_finish;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

`ifdef UNCACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [63:0] FA  = 64'h0000_0000_3000_0000;
  localparam logic [63:0] FD  = 64'h0000_0013_0000_0013;
  localparam logic [63:0] DA  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] DA2 = 64'h0000_0000_1000_0040;

  uncache_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_addr       (if_addr),
    .if_re         (if_re),
    .if_data       (if_data),
    .if_finish     (if_finish),
    .dm_addr       (dm_addr),
    .dm_data       (dm_data),
    .dm_mask       (dm_mask),
    .dm_we         (dm_we),
    .dm_re         (dm_re),
    .dm_rdata      (dm_rdata),
    .dm_finish     (dm_finish),
    .arb_addr      (arb_addr),
    .arb_data      (arb_data),
    .arb_mask      (arb_mask),
    .arb_we        (arb_we),
    .arb_re        (arb_re),
    .in_arb_data   (in_arb_data),
    .in_arb_finish (in_arb_finish),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        if_re;
    logic [63:0] if_addr;
    logic        dm_we;
    logic        dm_re;
    logic [63:0] dm_addr;
    logic [63:0] dm_data;
    logic [7:0]  dm_mask;
    logic        fin;
    logic [63:0] fin_data;
    logic        busy;
    logic        awe;
    logic        are;
    logic [63:0] aaddr;
    logic [63:0] adata;
    logic [7:0]  amask;
    logic        if_f;
    logic        dm_f;
    logic [63:0] ifd;
    logic [63:0] dmd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_re = 0; if_addr = 0; dm_we = 0; dm_re = 0; dm_addr = 0; dm_data = 0; dm_mask = 0;
    in_arb_finish = 0; in_arb_data = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();

    //            rst ifre addr  we re dm_addr            dm_data  mask   fin fdata              busy we re aaddr             adata  amask  iff dmf ifd dmd
    vecs.push_back('{1, 0, 0,  0, 0, 0,                  0,       8'h00, 0, 0,                 0, 0, 0, 0,                 0,     8'h00, 0, 0, 0, 0});
    vecs.push_back('{0, 1, FA, 0, 0, 0,                  0,       8'h00, 0, 0,                 1, 0, 1, FA,                0,     8'hFF, 0, 0, 0, 0});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{0, 1, FA, 0, 0, 0,                0,       8'h00, 0, 0,                 1, 0, 1, FA,                0,     8'hFF, 0, 0, 0, 0});
    vecs.push_back('{0, 1, FA, 0, 0, 0,                  0,       8'h00, 1, FD,                1, 0, 0, FA,                0,     8'hFF, 1, 0, FD, 0});
    vecs.push_back('{0, 1, FA, 0, 0, 0,                  0,       8'h00, 0, 0,                 0, 0, 0, FA,                0,     8'hFF, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 0, 0,                  0,       8'h00, 0, 0,                 0, 0, 0, FA,                0,     8'hFF, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  1, 0, DA,                 64'h41,  8'h01, 0, 0,                 1, 1, 0, DA,                64'h41, 8'h01, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  1, 0, DA2,                64'h99,  8'hFF, 0, 0,                 1, 1, 0, DA,                64'h41, 8'h01, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  1, 0, DA2,                64'h99,  8'hFF, 1, 64'hDEAD_BEEF,     1, 0, 0, DA,                64'h41, 8'h01, 0, 1, 0, 64'hDEAD_BEEF});
    vecs.push_back('{0, 0, 0,  1, 0, DA,                 64'h41,  8'h01, 0, 0,                 0, 0, 0, DA,                64'h41, 8'h01, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 0, 0,                  0,       8'h00, 1, 64'h5555,          0, 0, 0, DA,                64'h41, 8'h01, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  1, 1, 64'h1000_0008,      64'h77,  8'hF0, 0, 0,                 1, 1, 0, 64'h1000_0008,     64'h77, 8'hF0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  1, 1, 64'h1000_0008,      64'h77,  8'hF0, 1, 64'h5,             1, 0, 0, 64'h1000_0008,     64'h77, 8'hF0, 0, 1, 0, 64'h5});
    vecs.push_back('{0, 0, 0,  0, 0, 0,                  0,       8'h00, 0, 0,                 0, 0, 0, 64'h1000_0008,     64'h77, 8'hF0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 1, 64'h2000,           0,       8'hFF, 0, 0,                 1, 0, 1, 64'h2000,          0,     8'hFF, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  0, 1, 64'h2000,           0,       8'hFF, 1, 64'h1234,          1, 0, 0, 64'h2000,          0,     8'hFF, 0, 1, 0, 64'h1234});
    vecs.push_back('{0, 0, 0,  0, 0, 0,                  0,       8'h00, 0, 0,                 0, 0, 0, 64'h2000,          0,     8'hFF, 0, 0, 0, 0});

    for (int v = 0; v < vecs.size(); v++) begin
      rst = vecs[v].rst; if_re = vecs[v].if_re; if_addr = vecs[v].if_addr;
      dm_we = vecs[v].dm_we; dm_re = vecs[v].dm_re; dm_addr = vecs[v].dm_addr;
      dm_data = vecs[v].dm_data; dm_mask = vecs[v].dm_mask;
      in_arb_finish = vecs[v].fin; in_arb_data = vecs[v].fin_data;
      tick();
      chk($sformatf("v%0d busy", v),      busy,      vecs[v].busy);
      chk($sformatf("v%0d arb_we", v),    arb_we,    vecs[v].awe);
      chk($sformatf("v%0d arb_re", v),    arb_re,    vecs[v].are);
      chk($sformatf("v%0d arb_addr", v),  arb_addr,  vecs[v].aaddr);
      chk($sformatf("v%0d arb_data", v),  arb_data,  vecs[v].adata);
      chk($sformatf("v%0d arb_mask", v),  arb_mask,  vecs[v].amask);
      chk($sformatf("v%0d if_finish", v), if_finish, vecs[v].if_f);
      chk($sformatf("v%0d dm_finish", v), dm_finish, vecs[v].dm_f);
      chk($sformatf("v%0d if_data", v),   if_data,   vecs[v].ifd);
      chk($sformatf("v%0d dm_rdata", v),  dm_rdata,  vecs[v].dmd);
    end

    // Simultaneous requests straight out of reset.
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    if_re = 1; if_addr = FA;
    dm_re = 1; dm_addr = DA2; dm_mask = 8'h0F;
    tick();
    chk("sim first arb_addr", arb_addr, RR ? FA : DA2);
    chk("sim first arb_mask", arb_mask, RR ? 8'hFF : 8'h0F);
    chk("sim first arb_re", arb_re, 1);
    tick();
    in_arb_finish = 1; in_arb_data = 64'hA5A5;
    tick();
    in_arb_finish = 0;
    chk("sim first if_finish", if_finish, RR ? 1 : 0);
    chk("sim first dm_finish", dm_finish, RR ? 0 : 1);
    chk("sim first data", RR ? if_data : dm_rdata, 64'hA5A5);
    if (RR) if_re = 0;
    else dm_re = 0;
    tick();
    chk("sim M+2 busy", busy, 0);
    chk("sim M+2 arb_re", arb_re, 0);
    chk("sim M+2 no finish", {if_finish, dm_finish}, 0);
    tick();
    chk("sim M+3 arb_re", arb_re, 1);
    chk("sim M+3 arb_addr", arb_addr, RR ? DA2 : FA);
    in_arb_finish = 1; in_arb_data = 64'h5A5A;
    tick();
    in_arb_finish = 0;
    chk("sim second if_finish", if_finish, RR ? 0 : 1);
    chk("sim second dm_finish", dm_finish, RR ? 1 : 0);
    chk("sim second data", RR ? dm_rdata : if_data, 64'h5A5A);
    if_re = 0; dm_re = 0;
    tick();
    chk("sim end busy", busy, 0);

    // Reset while a data read is on the bus; the later completion must be dropped.
    idle_inputs();
    dm_re = 1; dm_addr = DA; dm_mask = 8'hFF;
    tick();
    chk("rstmid arb_re", arb_re, 1);
    tick();
    rst = 1; dm_re = 0;
    tick();
    rst = 0;
    chk("rstmid busy", busy, 0);
    chk("rstmid arb_re", arb_re, 0);
    chk("rstmid arb_addr", arb_addr, 0);
    chk("rstmid arb_mask", arb_mask, 0);
    chk("rstmid finish", {if_finish, dm_finish}, 0);
    tick();
    in_arb_finish = 1; in_arb_data = 64'hFFFF;
    tick();
    in_arb_finish = 0;
    chk("rstmid stale busy", busy, 0);
    chk("rstmid stale dm_finish", dm_finish, 0);
    chk("rstmid stale dm_rdata", dm_rdata, 0);
    tick();
    chk("rstmid after busy", busy, 0);
    chk("rstmid after finish", {if_finish, dm_finish}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
